sdram_arbiter: RTL and testbench



---
 rtl/sdram_arbiter_pkg.sv | 22 ++
 rtl/sdram_arbiter.sv | 159 +++++++++++++++
 tb/tb_sdram_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arbiter_pkg.sv
// Shared SDRAM command codes and arbiter state type.
// Commands are packed as {cs_n, ras_n, cas_n, we_n}.
package sdram_arbiter_pkg;

   localparam logic [3:0] CMD_LOAD_MODE_REGISTER = 4'b0000;
   localparam logic [3:0] CMD_REFRESH            = 4'b0001;
   localparam logic [3:0] CMD_PRECHARGE          = 4'b0010;
   localparam logic [3:0] CMD_ACTIVE             = 4'b0011;
   localparam logic [3:0] CMD_WRITE              = 4'b0100;
   localparam logic [3:0] CMD_READ               = 4'b0101;
   localparam logic [3:0] CMD_BURST_STOP         = 4'b0110;
   localparam logic [3:0] CMD_NO_OPERATION       = 4'b0111;

   typedef enum logic [2:0] {
      StIdle,
      StArbit,
      StAref,
      StWrite,
      StRead
   } arb_state_e;

endpackage

// File: rtl/sdram_arbiter.sv
// Shares the SDRAM command/address/data bus between the init, refresh, write and read engines.
// Init owns the bus until init_end_i; afterwards fixed priority refresh > write > read.
module sdram_arbiter
   import sdram_arbiter_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 13
) (
   input  logic              sys_clk_i,
   input  logic              rst_n_i,

   input  logic [3:0]        init_cmd_i,
   input  logic [1:0]        init_ba_i,
   input  logic [ADDR_W-1:0] init_addr_i,
   input  logic              init_end_i,

   input  logic              aref_req_i,
   input  logic              aref_end_i,
   input  logic [3:0]        aref_cmd_i,
   input  logic [1:0]        aref_ba_i,
   input  logic [ADDR_W-1:0] aref_addr_i,

   input  logic              wr_req_i,
   input  logic              wr_end_i,
   input  logic [3:0]        wr_cmd_i,
   input  logic [1:0]        wr_ba_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic              wr_sdram_en_i,
   input  logic [DATA_W-1:0] wr_data_i,

   input  logic              rd_req_i,
   input  logic              rd_end_i,
   input  logic [3:0]        rd_cmd_i,
   input  logic [1:0]        rd_ba_i,
   input  logic [ADDR_W-1:0] rd_addr_i,

   output logic              aref_en_o,
   output logic              wr_en_o,
   output logic              rd_en_o,

   output logic              sdram_cke_o,
   output logic              sdram_cs_n_o,
   output logic              sdram_ras_n_o,
   output logic              sdram_cas_n_o,
   output logic              sdram_we_n_o,
   output logic [1:0]        sdram_ba_o,
   output logic [ADDR_W-1:0] sdram_addr_o,
   output logic [DATA_W-1:0] sdram_dq_o,
   output logic              sdram_dq_oe_o
);

   arb_state_e        r_state;
   logic              r_aref_en;
   logic              r_wr_en;
   logic              r_rd_en;
   logic [3:0]        w_cmd;
   logic [1:0]        w_ba;
   logic [ADDR_W-1:0] w_addr;

   // Grants are set on the same edge as the state, so each is high exactly in its state.
   always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state   <= StIdle;
         r_aref_en <= 1'b0;
         r_wr_en   <= 1'b0;
         r_rd_en   <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               if (init_end_i) r_state <= StArbit;
            end
            StArbit: begin
               if (aref_req_i) begin
                  r_state   <= StAref;
                  r_aref_en <= 1'b1;
               end else if (wr_req_i) begin
                  r_state <= StWrite;
                  r_wr_en <= 1'b1;
               end else if (rd_req_i) begin
                  r_state <= StRead;
                  r_rd_en <= 1'b1;
               end
            end
            StAref: begin
               if (aref_end_i) begin
                  r_state   <= StArbit;
                  r_aref_en <= 1'b0;
               end
            end
            StWrite: begin
               if (wr_end_i) begin
                  r_state <= StArbit;
                  r_wr_en <= 1'b0;
               end
            end
            StRead: begin
               if (rd_end_i) begin
                  r_state <= StArbit;
                  r_rd_en <= 1'b0;
               end
            end
            default: begin
               r_state   <= StIdle;
               r_aref_en <= 1'b0;
               r_wr_en   <= 1'b0;
               r_rd_en   <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      w_cmd  = CMD_NO_OPERATION;
      w_ba   = 2'b11;
      w_addr = '1;
      case (r_state)
         StIdle: begin
            w_cmd  = init_cmd_i;
            w_ba   = init_ba_i;
            w_addr = init_addr_i;
         end
         StAref: begin
            w_cmd  = aref_cmd_i;
            w_ba   = aref_ba_i;
            w_addr = aref_addr_i;
         end
         StWrite: begin
            w_cmd  = wr_cmd_i;
            w_ba   = wr_ba_i;
            w_addr = wr_addr_i;
         end
         StRead: begin
            w_cmd  = rd_cmd_i;
            w_ba   = rd_ba_i;
            w_addr = rd_addr_i;
         end
         default: begin
            w_cmd  = CMD_NO_OPERATION;
            w_ba   = 2'b11;
            w_addr = '1;
         end
      endcase
   end

   assign aref_en_o     = r_aref_en;
   assign wr_en_o       = r_wr_en;
   assign rd_en_o       = r_rd_en;
   assign sdram_cke_o   = 1'b1;
   assign sdram_cs_n_o  = w_cmd[3];
   assign sdram_ras_n_o = w_cmd[2];
   assign sdram_cas_n_o = w_cmd[1];
   assign sdram_we_n_o  = w_cmd[0];
   assign sdram_ba_o    = w_ba;
   assign sdram_addr_o  = w_addr;
   assign sdram_dq_o    = wr_data_i;
   // Decoded from the async-reset state, so it drops as soon as reset asserts.
   assign sdram_dq_oe_o = (r_state == StWrite) && wr_sdram_en_i;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: vector table, directed corner cases, random vs model.
module tb_sdram_arbiter;

   localparam int DW = 16;
   localparam int AW = 13;
   localparam logic [3:0] NOP = 4'b0111;
   localparam logic [3:0] PRE = 4'b0010;
   localparam logic [3:0] REF = 4'b0001;
   localparam logic [3:0] WRC = 4'b0100;
   localparam logic [3:0] RDC = 4'b0101;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          init_end;
   logic [3:0]    init_cmd, aref_cmd, wr_cmd, rd_cmd;
   logic [1:0]    init_ba, aref_ba, wr_ba, rd_ba;
   logic [AW-1:0] init_addr, aref_addr, wr_addr, rd_addr;
   logic [2:0]    req;   // [2]=aref [1]=wr [0]=rd
   logic [2:0]    ends;
   logic          wr_sdram_en;
   logic [DW-1:0] wr_data;

   logic          aref_en, wr_en, rd_en, cke, cs_n, ras_n, cas_n, we_n, dq_oe;
   logic [1:0]    ba;
   logic [AW-1:0] addr;
   logic [DW-1:0] dq;

   sdram_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .sys_clk_i(clk), .rst_n_i(rst_n),
      .init_cmd_i(init_cmd), .init_ba_i(init_ba), .init_addr_i(init_addr),
      .init_end_i(init_end),
      .aref_req_i(req[2]), .aref_end_i(ends[2]), .aref_cmd_i(aref_cmd),
      .aref_ba_i(aref_ba), .aref_addr_i(aref_addr),
      .wr_req_i(req[1]), .wr_end_i(ends[1]), .wr_cmd_i(wr_cmd),
      .wr_ba_i(wr_ba), .wr_addr_i(wr_addr),
      .wr_sdram_en_i(wr_sdram_en), .wr_data_i(wr_data),
      .rd_req_i(req[0]), .rd_end_i(ends[0]), .rd_cmd_i(rd_cmd),
      .rd_ba_i(rd_ba), .rd_addr_i(rd_addr),
      .aref_en_o(aref_en), .wr_en_o(wr_en), .rd_en_o(rd_en),
      .sdram_cke_o(cke), .sdram_cs_n_o(cs_n), .sdram_ras_n_o(ras_n),
      .sdram_cas_n_o(cas_n), .sdram_we_n_o(we_n),
      .sdram_ba_o(ba), .sdram_addr_o(addr), .sdram_dq_o(dq), .sdram_dq_oe_o(dq_oe)
   );

   int total = 0;
   int bad   = 0;
   // Bus owner: -2 init engine (not yet done), -1 nobody (NOP), 0..2 engine index as in req.
   int own;

   typedef struct {
      logic       init_end;
      logic [2:0] req;
      logic [2:0] ends;
      logic [2:0] exp_gnt;
   } vec_t;
   vec_t tbl[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_edge();
      if (own == -2) begin
         if (init_end) own = -1;
      end else if (own == -1) begin
         for (int e = 2; e >= 0; e--)
            if (own == -1 && req[e]) own = e;
      end else if (ends[own]) begin
         own = -1;
      end
   endtask

   task automatic check_all();
      logic [3:0]    ec;
      logic [1:0]    eb;
      logic [AW-1:0] ea;
      case (own)
         -2:      begin ec = init_cmd; eb = init_ba; ea = init_addr; end
         2:       begin ec = aref_cmd; eb = aref_ba; ea = aref_addr; end
         1:       begin ec = wr_cmd;   eb = wr_ba;   ea = wr_addr;   end
         0:       begin ec = rd_cmd;   eb = rd_ba;   ea = rd_addr;   end
         default: begin ec = NOP;      eb = 2'b11;   ea = '1;        end
      endcase
      chk("grant", {29'd0, aref_en, wr_en, rd_en}, {29'd0, own == 2, own == 1, own == 0});
      chk("cmd", {28'd0, cs_n, ras_n, cas_n, we_n}, {28'd0, ec});
      chk("ba", {30'd0, ba}, {30'd0, eb});
      chk("addr", {19'd0, addr}, {19'd0, ea});
      chk("dq_oe", {31'd0, dq_oe}, {31'd0, (own == 1) && wr_sdram_en});
      chk("dq", {16'd0, dq}, {16'd0, wr_data});
      chk("cke", {31'd0, cke}, 32'd1);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic idle_inputs();
      init_end = 1'b0; req = '0; ends = '0; wr_sdram_en = 1'b0; wr_data = '0;
   endtask

   initial begin
      int order[$];
      int gaps[$];
      int nops, prev, g;
      int cnt[3];
      bit act[3];

      idle_inputs();
      init_cmd = PRE; init_ba = 2'b01; init_addr = 13'h0400;
      aref_cmd = REF; aref_ba = 2'b00; aref_addr = 13'h0011;
      wr_cmd = WRC;   wr_ba = 2'b10;   wr_addr = 13'h0222;
      rd_cmd = RDC;   rd_ba = 2'b01;   rd_addr = 13'h1333;
      own = -2;

      // Reset values, then init window of 20 cycles showing Precharge.
      #1 check_all();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("init_pre", {28'd0, cs_n, ras_n, cas_n, we_n}, {28'd0, PRE});
      end
      init_end = 1'b1;
      step();
      chk("init_nop", {28'd0, cs_n, ras_n, cas_n, we_n}, {28'd0, NOP});

      tbl[0]  = '{1'b1, 3'b000, 3'b000, 3'b000};
      tbl[1]  = '{1'b1, 3'b111, 3'b000, 3'b100};
      tbl[2]  = '{1'b1, 3'b011, 3'b100, 3'b000};
      tbl[3]  = '{1'b1, 3'b011, 3'b000, 3'b010};
      tbl[4]  = '{1'b0, 3'b001, 3'b010, 3'b000};
      tbl[5]  = '{1'b0, 3'b001, 3'b000, 3'b001};
      tbl[6]  = '{1'b0, 3'b100, 3'b001, 3'b000};
      tbl[7]  = '{1'b0, 3'b100, 3'b000, 3'b100};
      tbl[8]  = '{1'b0, 3'b000, 3'b011, 3'b100};
      tbl[9]  = '{1'b0, 3'b000, 3'b100, 3'b000};
      tbl[10] = '{1'b0, 3'b000, 3'b111, 3'b000};
      tbl[11] = '{1'b0, 3'b010, 3'b000, 3'b010};
      tbl[12] = '{1'b0, 3'b000, 3'b000, 3'b010};
      tbl[13] = '{1'b1, 3'b000, 3'b010, 3'b000};
      for (int r = 0; r < 14; r++) begin
         init_end = tbl[r].init_end; req = tbl[r].req; ends = tbl[r].ends;
         step();
         chk($sformatf("tbl_gnt%0d", r), {29'd0, aref_en, wr_en, rd_en}, {29'd0, tbl[r].exp_gnt});
      end

      // Write data drive in WRITE, suppressed in READ.
      idle_inputs();
      req = 3'b010; wr_sdram_en = 1'b1; wr_data = 16'hA5A5;
      step();
      req = '0;
      chk("wr_oe", {31'd0, dq_oe}, 32'd1);
      chk("wr_dq", {16'd0, dq}, 32'h0000A5A5);
      ends = 3'b010;
      step();
      ends = '0; req = 3'b001;
      step();
      req = '0;
      chk("rd_oe", {31'd0, dq_oe}, 32'd0);
      ends = 3'b001;
      step();

      // All three request together; each ends on its 4th granted cycle.
      idle_inputs();
      req = 3'b111; nops = 0; prev = -1; cnt = '{0, 0, 0};
      for (int c = 0; c < 60; c++) begin
         step();
         ends = '0;
         g = aref_en ? 2 : wr_en ? 1 : rd_en ? 0 : -1;
         if (g >= 0 && g != prev) begin
            order.push_back(g);
            gaps.push_back(nops);
            nops = 0;
         end else if (g < 0 && order.size() > 0) begin
            nops++;
         end
         prev = g;
         if (g >= 0) begin
            req[g] = 1'b0;
            cnt[g]++;
            if (cnt[g] == 4) ends[g] = 1'b1;
         end
      end
      chk("b2b_count", order.size(), 3);
      if (order.size() == 3) begin
         chk("b2b_first", order[0], 2);
         chk("b2b_second", order[1], 1);
         chk("b2b_third", order[2], 0);
         chk("b2b_gap1", gaps[1], 1);
         chk("b2b_gap2", gaps[2], 1);
      end

      // Asynchronous reset in the middle of a write.
      idle_inputs();
      req = 3'b010;
      step();
      req = '0; wr_sdram_en = 1'b1;
      step();
      chk("pre_rst_wr", {31'd0, wr_en}, 32'd1);
      #2 rst_n = 1'b0;
      own = -2;
      #1;
      chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
      chk("rst_dq_oe", {31'd0, dq_oe}, 32'd0);
      check_all();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      req = 3'b010;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("post_rst_nogrant", {31'd0, wr_en}, 32'd0);
      end
      init_end = 1'b1;
      step();
      step();
      chk("post_rst_grant", {31'd0, wr_en}, 32'd1);
      req = '0; ends = 3'b010;
      step();
      ends = '0;

      // Random engines: request, hold until granted, end after 1..5 cycles; stray ends injected.
      act = '{0, 0, 0};
      for (int c = 0; c < 2000; c++) begin
         init_cmd = 4'($urandom); init_ba = 2'($urandom); init_addr = AW'($urandom);
         aref_cmd = 4'($urandom); aref_ba = 2'($urandom); aref_addr = AW'($urandom);
         wr_cmd = 4'($urandom);   wr_ba = 2'($urandom);   wr_addr = AW'($urandom);
         rd_cmd = 4'($urandom);   rd_ba = 2'($urandom);   rd_addr = AW'($urandom);
         wr_sdram_en = 1'($urandom); wr_data = DW'($urandom);
         init_end = 1'($urandom);
         for (int e = 0; e < 3; e++) begin
            ends[e] = 1'b0;
            if (own == e) begin
               req[e] = 1'b0;
               if (!act[e]) begin
                  act[e] = 1'b1;
                  cnt[e] = int'($urandom_range(1, 5));
               end
               cnt[e]--;
               if (cnt[e] == 0) begin
                  ends[e] = 1'b1;
                  act[e] = 1'b0;
               end
            end else begin
               if ($urandom_range(0, 7) == 0) ends[e] = 1'b1;
               if (!req[e] && $urandom_range(0, 2) == 0) req[e] = 1'b1;
            end
         end
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

endmodule
